// File: rtl/scarv_cpu_cop_bridge.sv
// scarv_cpu_cop_bridge
// CPU-side initiator for the CPU/COP instruction interface. Issues host
// instructions to the COP on the cpu_insn_req/cop_insn_ack handshake, tracks
// instructions the COP has accepted but not finished, takes results on the
// cop_insn_rsp/cpu_insn_ack handshake and forwards GPR writebacks and result
// codes to the host.
//
// Ports:
//   g_clk, g_reset                     clock, synchronous active-high reset
//   host_valid/host_ready              host issue handshake
//   host_enc, host_rs1, host_flush     instruction, operand, pipeline flush
//   cpu_insn_req/cop_insn_ack          request handshake to the COP
//   cpu_abort_req                      one-cycle abort of a pending request
//   cpu_insn_enc, cpu_rs1              request payload, stable while requesting
//   cop_wen/waddr/wdata/result         COP result payload
//   cop_insn_rsp/cpu_insn_ack          result handshake
//   wb_ready                           host writeback port free
//   gpr_wen/waddr/wdata                GPR writeback (registered)
//   cmpl_valid, cmpl_result            completion pulse and result code
//   busy                               work in flight or request pending
//
// Optional feature macro: SCARV_COP_BRIDGE_WDT_EN adds a watchdog that
// aborts and reports result 3'b111 after WDT_CYCLES cycles without a finish.
//
// States:
//   IDLE | no request to the COP; host may issue when below the limit
//   REQ  | request presented to the COP, payload held until accept

module scarv_cpu_cop_bridge #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int WDT_CYCLES      = 255
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [31:0] host_enc,
    input  logic [31:0] host_rs1,
    input  logic        host_flush,
    output logic        cpu_insn_req,
    input  logic        cop_insn_ack,
    output logic        cpu_abort_req,
    output logic [31:0] cpu_insn_enc,
    output logic [31:0] cpu_rs1,
    input  logic        cop_wen,
    input  logic [4:0]  cop_waddr,
    input  logic [31:0] cop_wdata,
    input  logic [2:0]  cop_result,
    input  logic        cop_insn_rsp,
    output logic        cpu_insn_ack,
    input  logic        wb_ready,
    output logic        gpr_wen,
    output logic [4:0]  gpr_waddr,
    output logic [31:0] gpr_wdata,
    output logic        cmpl_valid,
    output logic [2:0]  cmpl_result,
    output logic        busy
);

    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 7 || WDT_CYCLES < 1) begin : g_param_check
        $error("scarv_cpu_cop_bridge: MAX_OUTSTANDING must be 1..7 and WDT_CYCLES >= 1");
    end

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [2:0] count;
    logic       accept, finish, finish_eff, issue, flush_abort, wdt_fire;

    assign accept       = cpu_insn_req & cop_insn_ack;
    assign cpu_insn_ack = (count != 3'd0) & wb_ready;
    assign finish       = cop_insn_rsp & cpu_insn_ack;
    assign issue        = host_valid & host_ready;
    // Accept wins over a flush in the same cycle.
    assign flush_abort  = (state == REQ) & host_flush & ~cop_insn_ack;
    assign finish_eff   = finish & ~wdt_fire;
    assign busy         = (count != 3'd0) | cpu_insn_req;

`ifdef SCARV_COP_BRIDGE_WDT_EN
    localparam int WDT_W = ($clog2(WDT_CYCLES + 1) > 8) ? $clog2(WDT_CYCLES + 1) : 8;
    logic [WDT_W-1:0] wdt_cnt;

    always_ff @(posedge g_clk) begin
        if (g_reset || count == 3'd0 || finish || wdt_fire) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end

    // Fires on the WDT_CYCLES-th consecutive cycle without a finish.
    assign wdt_fire = (count != 3'd0) & (wdt_cnt == WDT_W'(WDT_CYCLES - 1));
`else
    assign wdt_fire = 1'b0;
`endif

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue) state_nxt = REQ;
            REQ:  if (accept || host_flush || wdt_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_insn_req = (state == REQ);
        host_ready   = (state == IDLE) & (count < MAX_CNT) & ~host_flush & ~g_reset;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            cpu_insn_enc  <= '0;
            cpu_rs1       <= '0;
            cpu_abort_req <= 1'b0;
            count         <= '0;
        end else begin
            if (issue) begin
                cpu_insn_enc <= host_enc;
                cpu_rs1      <= host_rs1;
            end
            cpu_abort_req <= flush_abort | wdt_fire;
            if (wdt_fire) begin
                count <= '0;
            end else if (accept && !finish_eff && count < MAX_CNT) begin
                count <= count + 3'd1;
            end else if (finish_eff && !accept && count != 3'd0) begin
                count <= count - 3'd1;
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            cmpl_valid  <= 1'b0;
            cmpl_result <= '0;
            gpr_wen     <= 1'b0;
            gpr_waddr   <= '0;
            gpr_wdata   <= '0;
        end else begin
            cmpl_valid <= finish_eff | wdt_fire;
            gpr_wen    <= 1'b0;
            if (wdt_fire) begin
                cmpl_result <= 3'b111;
            end else if (finish) begin
                cmpl_result <= cop_result;
                gpr_waddr   <= cop_waddr;
                gpr_wdata   <= cop_wdata;
                gpr_wen     <= cop_wen & (cop_waddr != 5'd0);
            end
        end
    end

endmodule

// File: tb/tb_scarv_cpu_cop_bridge.sv
module tb_scarv_cpu_cop_bridge;

    localparam int MAXO = 2;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        host_valid, host_flush;
    logic [31:0] host_enc, host_rs1;
    logic        host_ready;
    logic        cpu_insn_req, cop_insn_ack, cpu_abort_req;
    logic [31:0] cpu_insn_enc, cpu_rs1;
    logic        cop_wen;
    logic [4:0]  cop_waddr;
    logic [31:0] cop_wdata;
    logic [2:0]  cop_result;
    logic        cop_insn_rsp, cpu_insn_ack, wb_ready;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        cmpl_valid;
    logic [2:0]  cmpl_result;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 g_clk = ~g_clk;

    scarv_cpu_cop_bridge #(.MAX_OUTSTANDING(MAXO), .WDT_CYCLES(255)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_enc(host_enc), .host_rs1(host_rs1), .host_flush(host_flush),
        .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
        .cpu_abort_req(cpu_abort_req), .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1),
        .cop_wen(cop_wen), .cop_waddr(cop_waddr), .cop_wdata(cop_wdata),
        .cop_result(cop_result), .cop_insn_rsp(cop_insn_rsp), .cpu_insn_ack(cpu_insn_ack),
        .wb_ready(wb_ready), .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .cmpl_valid(cmpl_valid), .cmpl_result(cmpl_result), .busy(busy)
    );

    typedef struct {
        logic        hv;
        logic [31:0] enc, rs1;
        logic        fl, ack, rsp, wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [2:0]  res;
        logic        wbr;
        logic        e_req, e_rdy, e_cack, e_ab, e_cv, e_gw, e_busy;
        logic [31:0] e_enc;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [2:0]  e_res;
    } vec_t;

    function automatic vec_t mk(
        input logic hv, input logic [31:0] enc, input logic [31:0] rs1,
        input logic fl, input logic ack, input logic rsp, input logic wen,
        input logic [4:0] wa, input logic [31:0] wd, input logic [2:0] res, input logic wbr,
        input logic e_req, input logic e_rdy, input logic e_cack, input logic e_ab,
        input logic e_cv, input logic e_gw, input logic e_busy,
        input logic [31:0] e_enc, input logic [4:0] e_wa, input logic [31:0] e_wd,
        input logic [2:0] e_res);
        vec_t v;
        v.hv = hv; v.enc = enc; v.rs1 = rs1; v.fl = fl; v.ack = ack; v.rsp = rsp;
        v.wen = wen; v.wa = wa; v.wd = wd; v.res = res; v.wbr = wbr;
        v.e_req = e_req; v.e_rdy = e_rdy; v.e_cack = e_cack; v.e_ab = e_ab;
        v.e_cv = e_cv; v.e_gw = e_gw; v.e_busy = e_busy;
        v.e_enc = e_enc; v.e_wa = e_wa; v.e_wd = e_wd; v.e_res = e_res;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        host_valid = 0; host_enc = 0; host_rs1 = 0; host_flush = 0;
        cop_insn_ack = 0; cop_insn_rsp = 0; cop_wen = 0; cop_waddr = 0;
        cop_wdata = 0; cop_result = 0; wb_ready = 0;
    endtask

    // Reference model state: requests in flight at the COP kept as a queue.
    logic        m_req, m_abort, m_cv, m_gw;
    logic [31:0] m_enc, m_rs1, m_wd;
    logic [4:0]  m_wa;
    logic [2:0]  m_res;
    logic [31:0] inflight[$];

    task automatic model_reset();
        m_req = 0; m_abort = 0; m_cv = 0; m_gw = 0;
        m_enc = 0; m_rs1 = 0; m_wd = 0; m_wa = 0; m_res = 0;
        inflight.delete();
    endtask

    vec_t tbl[30];

    initial begin
        logic m_rdy, m_cack, acc, fin;

        tbl[0]  = mk(1,32'h0000102B,32'hDEADBEEF,0,0,0,0,0,0,0,0, 0,1,0,0,0,0,0, 0,0,0,0);
        tbl[1]  = mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,1, 32'h102B,0,0,0);
        tbl[2]  = mk(0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,1, 32'h102B,0,0,0);
        tbl[3]  = mk(0,0,0,0,1,0,0,0,0,0,0, 1,0,0,0,0,0,1, 32'h102B,0,0,0);
        tbl[4]  = mk(0,0,0,0,0,1,1,5,32'h12345678,0,1, 0,1,1,0,0,0,1, 32'h102B,0,0,0);
        tbl[5]  = mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,1,1,0, 32'h102B,5,32'h12345678,0);
        tbl[6]  = mk(1,32'hAAAA0001,1,0,0,0,0,0,0,0,0, 0,1,0,0,0,0,0, 32'h102B,5,32'h12345678,0);
        tbl[7]  = mk(0,0,0,0,1,0,0,0,0,0,0, 1,0,0,0,0,0,1, 32'hAAAA0001,5,32'h12345678,0);
        tbl[8]  = mk(0,0,0,0,0,1,1,0,32'hFFFF,2,1, 0,1,1,0,0,0,1, 32'hAAAA0001,5,32'h12345678,0);
        tbl[9]  = mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,1,0,0, 32'hAAAA0001,0,32'hFFFF,2);
        tbl[10] = mk(1,32'h55,32'h66,0,0,0,0,0,0,0,0, 0,1,0,0,0,0,0, 32'hAAAA0001,0,32'hFFFF,2);
        tbl[11] = mk(0,0,0,1,0,0,0,0,0,0,0, 1,0,0,0,0,0,1, 32'h55,0,32'hFFFF,2);
        tbl[12] = mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,0,1,0,0,0, 32'h55,0,32'hFFFF,2);
        tbl[13] = mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,0,0,0, 32'h55,0,32'hFFFF,2);
        tbl[14] = mk(1,32'h77,32'h88,0,0,0,0,0,0,0,0, 0,1,0,0,0,0,0, 32'h55,0,32'hFFFF,2);
        tbl[15] = mk(0,0,0,1,1,0,0,0,0,0,0, 1,0,0,0,0,0,1, 32'h77,0,32'hFFFF,2);
        tbl[16] = mk(0,0,0,0,0,1,1,3,32'h33,1,0, 0,1,0,0,0,0,1, 32'h77,0,32'hFFFF,2);
        tbl[17] = mk(0,0,0,0,0,1,1,3,32'h33,1,0, 0,1,0,0,0,0,1, 32'h77,0,32'hFFFF,2);
        tbl[18] = mk(0,0,0,0,0,1,1,3,32'h33,1,1, 0,1,1,0,0,0,1, 32'h77,0,32'hFFFF,2);
        tbl[19] = mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,1,1,0, 32'h77,3,32'h33,1);
        tbl[20] = mk(1,1,0,0,0,0,0,0,0,0,0, 0,1,0,0,0,0,0, 32'h77,3,32'h33,1);
        tbl[21] = mk(0,0,0,0,1,0,0,0,0,0,0, 1,0,0,0,0,0,1, 1,3,32'h33,1);
        tbl[22] = mk(1,2,0,0,0,0,0,0,0,0,0, 0,1,0,0,0,0,1, 1,3,32'h33,1);
        tbl[23] = mk(0,0,0,0,1,0,0,0,0,0,0, 1,0,0,0,0,0,1, 2,3,32'h33,1);
        tbl[24] = mk(1,3,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1, 2,3,32'h33,1);
        tbl[25] = mk(0,0,0,0,0,1,0,7,9,0,1, 0,0,1,0,0,0,1, 2,3,32'h33,1);
        tbl[26] = mk(0,0,0,0,0,1,1,8,32'hA,4,1, 0,1,1,0,1,0,1, 2,7,9,0);
        tbl[27] = mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,1,1,0, 2,8,32'hA,4);
        tbl[28] = mk(0,0,0,0,0,1,1,9,5,3,1, 0,1,0,0,0,0,0, 2,8,32'hA,4);
        tbl[29] = mk(0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0,0,0,0, 2,8,32'hA,4);

        // Reset: every output low while reset is held.
        drive_idle();
        g_reset = 1;
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        #2;
        chk("rst_outputs", {host_ready, cpu_insn_req, cpu_abort_req, cpu_insn_ack,
                            gpr_wen, cmpl_valid, busy}, 0);
        chk("rst_data", cpu_insn_enc | cpu_rs1 | gpr_wdata | {27'd0, gpr_waddr} | {29'd0, cmpl_result}, 0);
        g_reset = 0;

        // Directed table: single issue, x0/error result, flush, wb backpressure, outstanding limit.
        for (int i = 0; i < 30; i++) begin
            @(negedge g_clk);
            host_valid = tbl[i].hv; host_enc = tbl[i].enc; host_rs1 = tbl[i].rs1;
            host_flush = tbl[i].fl; cop_insn_ack = tbl[i].ack; cop_insn_rsp = tbl[i].rsp;
            cop_wen = tbl[i].wen; cop_waddr = tbl[i].wa; cop_wdata = tbl[i].wd;
            cop_result = tbl[i].res; wb_ready = tbl[i].wbr;
            #2;
            chk($sformatf("t%0d_req", i), {31'd0, cpu_insn_req}, {31'd0, tbl[i].e_req});
            chk($sformatf("t%0d_host_ready", i), {31'd0, host_ready}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("t%0d_cpu_insn_ack", i), {31'd0, cpu_insn_ack}, {31'd0, tbl[i].e_cack});
            chk($sformatf("t%0d_abort", i), {31'd0, cpu_abort_req}, {31'd0, tbl[i].e_ab});
            chk($sformatf("t%0d_cmpl_valid", i), {31'd0, cmpl_valid}, {31'd0, tbl[i].e_cv});
            chk($sformatf("t%0d_gpr_wen", i), {31'd0, gpr_wen}, {31'd0, tbl[i].e_gw});
            chk($sformatf("t%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
            chk($sformatf("t%0d_enc", i), cpu_insn_enc, tbl[i].e_enc);
            chk($sformatf("t%0d_waddr", i), {27'd0, gpr_waddr}, {27'd0, tbl[i].e_wa});
            chk($sformatf("t%0d_wdata", i), gpr_wdata, tbl[i].e_wd);
            chk($sformatf("t%0d_result", i), {29'd0, cmpl_result}, {29'd0, tbl[i].e_res});
        end
        @(negedge g_clk);
        drive_idle();

        // Reset mid-transaction: one accepted, one requesting, then reset.
        @(negedge g_clk); host_valid = 1; host_enc = 32'h99;
        @(negedge g_clk); host_valid = 0; cop_insn_ack = 1;
        @(negedge g_clk); cop_insn_ack = 0; host_valid = 1; host_enc = 32'hAB;
        @(negedge g_clk); host_valid = 0;
        #2;
        chk("mid_req_before_reset", {31'd0, cpu_insn_req}, 1);
        g_reset = 1;
        @(negedge g_clk); g_reset = 0;
        #2;
        chk("mid_reset_req", {31'd0, cpu_insn_req}, 0);
        chk("mid_reset_busy", {31'd0, busy}, 0);
        chk("mid_reset_abort", {31'd0, cpu_abort_req}, 0);
        chk("mid_reset_enc", cpu_insn_enc, 0);
        @(negedge g_clk);
        #2;
        chk("mid_reset_abort_late", {31'd0, cpu_abort_req}, 0);
        chk("mid_reset_cack", {31'd0, cpu_insn_ack}, 0);

        // Randomized run against the reference model.
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge g_clk);
            host_valid   = 1'($urandom_range(0, 1));
            host_enc     = $urandom;
            host_rs1     = $urandom;
            host_flush   = ($urandom_range(0, 9) == 0);
            cop_insn_ack = ($urandom_range(0, 9) < 4);
            cop_insn_rsp = ($urandom_range(0, 9) < 4);
            cop_wen      = 1'($urandom_range(0, 1));
            cop_waddr    = 5'($urandom_range(0, 31));
            cop_wdata    = $urandom;
            cop_result   = 3'($urandom_range(0, 7));
            wb_ready     = ($urandom_range(0, 9) < 7);
            #2;
            m_rdy  = !m_req && (inflight.size() < MAXO) && !host_flush;
            m_cack = (inflight.size() != 0) && wb_ready;
            chk("r_req", {31'd0, cpu_insn_req}, {31'd0, m_req});
            chk("r_host_ready", {31'd0, host_ready}, {31'd0, m_rdy});
            chk("r_cpu_insn_ack", {31'd0, cpu_insn_ack}, {31'd0, m_cack});
            chk("r_abort", {31'd0, cpu_abort_req}, {31'd0, m_abort});
            chk("r_enc", cpu_insn_enc, m_enc);
            chk("r_rs1", cpu_rs1, m_rs1);
            chk("r_cmpl_valid", {31'd0, cmpl_valid}, {31'd0, m_cv});
            chk("r_gpr_wen", {31'd0, gpr_wen}, {31'd0, m_gw});
            chk("r_waddr", {27'd0, gpr_waddr}, {27'd0, m_wa});
            chk("r_wdata", gpr_wdata, m_wd);
            chk("r_result", {29'd0, cmpl_result}, {29'd0, m_res});
            chk("r_busy", {31'd0, busy}, {31'd0, (inflight.size() != 0) || m_req});

            acc     = m_req && cop_insn_ack;
            fin     = cop_insn_rsp && m_cack;
            m_abort = m_req && host_flush && !cop_insn_ack;
            if (!m_req && host_valid && m_rdy) begin
                m_req = 1; m_enc = host_enc; m_rs1 = host_rs1;
            end else if (m_req && (cop_insn_ack || host_flush)) begin
                m_req = 0;
            end
            if (acc) inflight.push_back(m_enc);
            if (fin) void'(inflight.pop_front());
            m_cv = fin;
            m_gw = fin && cop_wen && (cop_waddr != 0);
            if (fin) begin
                m_res = cop_result; m_wa = cop_waddr; m_wd = cop_wdata;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
